// File: rtl/fp_pkg.sv
// Shared floating-point format helpers for the multiplier/divider pair:
// default field widths, bias, special encodings and the sequencer state type.
package fp_pkg;

  localparam int FP_EXP_WIDTH  = 8;
  localparam int FP_MANT_WIDTH = 23;
  localparam int FP_WIDTH      = 1 + FP_EXP_WIDTH + FP_MANT_WIDTH;
  localparam int BIAS          = (1 << (FP_EXP_WIDTH - 1)) - 1;

  localparam logic [FP_WIDTH-1:0] FP_POS_ZERO = '0;
  localparam logic [FP_WIDTH-1:0] FP_NEG_ZERO = {1'b1, {(FP_WIDTH-1){1'b0}}};
  localparam logic [FP_WIDTH-1:0] FP_POS_INF  = {1'b0, {FP_EXP_WIDTH{1'b1}}, {FP_MANT_WIDTH{1'b0}}};
  localparam logic [FP_WIDTH-1:0] FP_NEG_INF  = {1'b1, {FP_EXP_WIDTH{1'b1}}, {FP_MANT_WIDTH{1'b0}}};
  localparam logic [FP_WIDTH-1:0] FP_QNAN     = {1'b0, {FP_EXP_WIDTH{1'b1}}, 1'b1, {(FP_MANT_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MULT,
    ST_NORM,
    ST_DONE
  } fpm_state_t;

  function automatic logic fp_sign(input logic [FP_WIDTH-1:0] x);
    return x[FP_WIDTH-1];
  endfunction

  function automatic logic [FP_EXP_WIDTH-1:0] fp_exp(input logic [FP_WIDTH-1:0] x);
    return x[FP_WIDTH-2 -: FP_EXP_WIDTH];
  endfunction

  function automatic logic [FP_MANT_WIDTH-1:0] fp_frac(input logic [FP_WIDTH-1:0] x);
    return x[FP_MANT_WIDTH-1:0];
  endfunction

endpackage

// File: rtl/fp_mant_mult_seq.sv
// Shift-add (MW+1)x(MW+1) mantissa multiplier: one multiplier bit per step,
// count_done flags the final (MW-th) iteration.
module fp_mant_mult_seq #(
  parameter int MW = 23
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              step,
  input  logic [MW:0]       mcand,
  input  logic [MW:0]       mplier,
  output logic [2*MW+1:0]   product,
  output logic              count_done
);

  localparam int CW = $clog2(MW + 1);

  logic [2*MW+1:0] mcand_reg;
  logic [2*MW+1:0] prod_reg;
  logic [MW:0]     mplier_reg;
  logic [CW-1:0]   count_reg;

  // The multiplicand walks left and the multiplier right, so the bit under
  // test is always mplier_reg[0] and no barrel shifter is needed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_reg  <= '0;
      prod_reg   <= '0;
      mplier_reg <= '0;
      count_reg  <= '0;
    end else if (load) begin
      mcand_reg  <= {{(MW+1){1'b0}}, mcand};
      prod_reg   <= '0;
      mplier_reg <= mplier;
      count_reg  <= '0;
    end else if (step) begin
      if (mplier_reg[0]) begin
        prod_reg <= prod_reg + mcand_reg;
      end
      mcand_reg  <= mcand_reg << 1;
      mplier_reg <= mplier_reg >> 1;
      count_reg  <= count_reg + CW'(1);
    end
  end

  assign product    = prod_reg;
  assign count_done = (count_reg == CW'(MW));

endmodule

// File: rtl/fp_multiplier_seq.sv
// Multi-cycle floating-point multiplier: start/busy/done handshake around a
// shift-add mantissa core, with exponent path and special-case resolution.
module fp_multiplier_seq
  import fp_pkg::*;
#(
  parameter int EXP_WIDTH      = 8,
  parameter int MANTISSA_WIDTH = 23
) (
  input  logic                                clk_in,
  input  logic                                rst_n_in,
  input  logic                                start_in,
  input  logic [EXP_WIDTH+MANTISSA_WIDTH:0]   a_in,
  input  logic [EXP_WIDTH+MANTISSA_WIDTH:0]   b_in,
  output logic                                busy_out,
  output logic                                done_out,
  output logic [EXP_WIDTH+MANTISSA_WIDTH:0]   fpm_out,
  output logic                                overflow_out,
  output logic                                underflow_out
);

  localparam int W   = 1 + EXP_WIDTH + MANTISSA_WIDTH;
  localparam int M   = MANTISSA_WIDTH;
  localparam int EW2 = EXP_WIDTH + 2;
  localparam logic signed [EW2-1:0] EXP_BIAS = EW2'((1 << (EXP_WIDTH - 1)) - 1);
  localparam logic signed [EW2-1:0] EXP_MAX  = EW2'((1 << EXP_WIDTH) - 1);

  fpm_state_t state_reg, state_next;
  logic       mult_load, mult_step, count_done;
  logic [2*M+1:0] prod;

  logic [EXP_WIDTH-1:0]   ea_in, eb_in;
  logic [EXP_WIDTH-1:0]   ea_reg, eb_reg;
  logic                   sign_reg;
  logic signed [EW2-1:0]  exp_sum, exp_reg, exp_norm;

  logic [W-1:0] fpm_reg, res_next;
  logic         ovf_reg, unf_reg, ovf_next, unf_next;
  logic         norm_shift, a_inf, b_inf, a_zero, b_zero, exp_neg;
  logic [M-1:0] frac_norm;
  logic         unused_prod_low;

  assign ea_in   = a_in[W-2 -: EXP_WIDTH];
  assign eb_in   = b_in[W-2 -: EXP_WIDTH];
  assign exp_sum = $signed({2'b00, ea_in}) + $signed({2'b00, eb_in}) - EXP_BIAS;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    mult_load  = 1'b0;
    mult_step  = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (start_in) begin
          mult_load  = 1'b1;
          state_next = ST_MULT;
        end
      end
      ST_MULT: begin
        mult_step = 1'b1;
        if (count_done) begin
          state_next = ST_NORM;
        end
      end
      ST_NORM: state_next = ST_DONE;
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Operand fields are captured only on acceptance; later start pulses
  // never reach these registers.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      ea_reg   <= '0;
      eb_reg   <= '0;
      sign_reg <= 1'b0;
      exp_reg  <= '0;
    end else if (mult_load) begin
      ea_reg   <= ea_in;
      eb_reg   <= eb_in;
      sign_reg <= a_in[W-1] ^ b_in[W-1];
      exp_reg  <= exp_sum;
    end
  end

  fp_mant_mult_seq #(
    .MW(M)
  ) u_mant (
    .clk        (clk_in),
    .rst_n      (rst_n_in),
    .load       (mult_load),
    .step       (mult_step),
    .mcand      ({1'b1, a_in[M-1:0]}),
    .mplier     ({1'b1, b_in[M-1:0]}),
    .product    (prod),
    .count_done (count_done)
  );

  assign unused_prod_low = ^prod[M-1:0];
  assign norm_shift = prod[2*M+1];
  assign frac_norm  = norm_shift ? prod[2*M -: M] : prod[2*M-1 -: M];
  assign exp_norm   = exp_reg + $signed(EW2'(norm_shift));
  assign exp_neg    = exp_norm[EW2-1];

  assign a_inf  = &ea_reg;
  assign b_inf  = &eb_reg;
  assign a_zero = ~|ea_reg;
  assign b_zero = ~|eb_reg;

  always_comb begin
    res_next = {sign_reg, exp_norm[EXP_WIDTH-1:0], frac_norm};
    ovf_next = 1'b0;
    unf_next = 1'b0;
    if ((a_inf && b_zero) || (b_inf && a_zero)) begin
      res_next = {1'b0, {EXP_WIDTH{1'b1}}, 1'b1, {(M-1){1'b0}}};
    end else if (a_inf || b_inf) begin
      res_next = {sign_reg, {EXP_WIDTH{1'b1}}, {M{1'b0}}};
    end else if (a_zero || b_zero) begin
      res_next = {sign_reg, {(W-1){1'b0}}};
    end else if (!exp_neg && (exp_norm >= EXP_MAX)) begin
      res_next = {sign_reg, {EXP_WIDTH{1'b1}}, {M{1'b0}}};
      ovf_next = 1'b1;
    end else if (exp_neg || (exp_norm == '0)) begin
      res_next = {sign_reg, {(W-1){1'b0}}};
      unf_next = 1'b1;
    end
  end

  // Result and flags change only on the NORM->DONE edge, so the previous
  // product stays visible throughout the next operation.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      fpm_reg <= '0;
      ovf_reg <= 1'b0;
      unf_reg <= 1'b0;
    end else if (state_reg == ST_NORM) begin
      fpm_reg <= res_next;
      ovf_reg <= ovf_next;
      unf_reg <= unf_next;
    end
  end

  assign busy_out      = (state_reg != ST_IDLE);
  assign done_out      = (state_reg == ST_DONE);
  assign fpm_out       = fpm_reg;
  assign overflow_out  = ovf_reg;
  assign underflow_out = unf_reg;

endmodule

// File: tb/tb_fp_multiplier_seq.sv
// Self-checking bench for fp_multiplier_seq: directed vector table, random
// operands against an arithmetic reference, handshake and reset sequences.
module tb_fp_multiplier_seq;

  logic        clk_in = 1'b0;
  logic        rst_n_in;
  logic        start_in;
  logic [31:0] a_in, b_in;
  logic        busy_out, done_out, overflow_out, underflow_out;
  logic [31:0] fpm_out;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk_in = ~clk_in;

  fp_multiplier_seq #(
    .EXP_WIDTH     (8),
    .MANTISSA_WIDTH(23)
  ) dut (
    .clk_in       (clk_in),
    .rst_n_in     (rst_n_in),
    .start_in     (start_in),
    .a_in         (a_in),
    .b_in         (b_in),
    .busy_out     (busy_out),
    .done_out     (done_out),
    .fpm_out      (fpm_out),
    .overflow_out (overflow_out),
    .underflow_out(underflow_out)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r;
    logic        o;
    logic        u;
  } vec_t;

  vec_t vecs[16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference: product of real mantissas, biased exponent sum, truncation.
  function automatic void ref_mul(input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic o, output logic u);
    int      ea, eb, e;
    longint  ma, mb, p, fr;
    logic    s;
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    s  = a[31] ^ b[31];
    o  = 1'b0;
    u  = 1'b0;
    if ((ea == 255 && eb == 0) || (eb == 255 && ea == 0)) begin
      r = 32'h7FC00000;
    end else if (ea == 255 || eb == 255) begin
      r = {s, 8'hFF, 23'h0};
    end else if (ea == 0 || eb == 0) begin
      r = {s, 31'h0};
    end else begin
      ma = longint'(a[22:0]) + 64'h800000;
      mb = longint'(b[22:0]) + 64'h800000;
      p  = ma * mb;
      e  = ea + eb - 127;
      if (p >= (64'd1 << 47)) begin
        e  = e + 1;
        fr = p >> 24;
      end else begin
        fr = p >> 23;
      end
      if (e >= 255) begin
        r = {s, 8'hFF, 23'h0};
        o = 1'b1;
      end else if (e <= 0) begin
        r = {s, 31'h0};
        u = 1'b1;
      end else begin
        r = {s, 8'(e), fr[22:0]};
      end
    end
  endfunction

  function automatic logic [31:0] rand_op();
    logic [7:0] e;
    int sel;
    sel = int'($urandom_range(0, 9));
    case (sel)
      0:       e = 8'd0;
      1:       e = 8'hFF;
      2, 3:    e = 8'($urandom_range(160, 254));
      4, 5:    e = 8'($urandom_range(1, 90));
      default: e = 8'($urandom_range(100, 155));
    endcase
    return {1'($urandom_range(0, 1)), e, 23'($urandom)};
  endfunction

  task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] r, output logic o, output logic u);
    int lat;
    lat = -1;
    @(negedge clk_in);
    chk("idle before start", 32'(busy_out), 32'd0);
    a_in     = a;
    b_in     = b;
    start_in = 1'b1;
    @(posedge clk_in);
    #1;
    start_in = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk_in);
      if (k == 1) chk("busy after accept", 32'(busy_out), 32'd1);
      if (done_out) begin
        lat = k;
        break;
      end
    end
    chk("latency", 32'(lat), 32'd26);
    r = fpm_out;
    o = overflow_out;
    u = underflow_out;
    @(negedge clk_in);
    chk("done single pulse", 32'(done_out), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r, er, a, b;
    logic        o, u, eo, eu;
    int          done_at[$];
    int          ndone;

    vecs[0]  = '{32'h3FC00000, 32'h40000000, 32'h40400000, 1'b0, 1'b0};
    vecs[1]  = '{32'h3FC00000, 32'h3FC00000, 32'h40100000, 1'b0, 1'b0};
    vecs[2]  = '{32'h71800000, 32'h71800000, 32'h7F800000, 1'b1, 1'b0};
    vecs[3]  = '{32'h0D800000, 32'h0D800000, 32'h00000000, 1'b0, 1'b1};
    vecs[4]  = '{32'hC0400000, 32'h00000000, 32'h80000000, 1'b0, 1'b0};
    vecs[5]  = '{32'h7F800000, 32'h00000000, 32'h7FC00000, 1'b0, 1'b0};
    vecs[6]  = '{32'h00000000, 32'hFF800000, 32'h7FC00000, 1'b0, 1'b0};
    vecs[7]  = '{32'hFF800000, 32'h40000000, 32'hFF800000, 1'b0, 1'b0};
    vecs[8]  = '{32'h3F800000, 32'h3F800000, 32'h3F800000, 1'b0, 1'b0};
    vecs[9]  = '{32'h7F000000, 32'h40000000, 32'h7F800000, 1'b1, 1'b0};
    vecs[10] = '{32'h7F000000, 32'h3F800000, 32'h7F000000, 1'b0, 1'b0};
    vecs[11] = '{32'h00800000, 32'h3F800000, 32'h00800000, 1'b0, 1'b0};
    vecs[12] = '{32'h00800000, 32'h3F000000, 32'h00000000, 1'b0, 1'b1};
    vecs[13] = '{32'h7F7FFFFF, 32'h3FFFFFFF, 32'h7F800000, 1'b1, 1'b0};
    vecs[14] = '{32'h3FFFFFFF, 32'h3FFFFFFF, 32'h407FFFFE, 1'b0, 1'b0};
    vecs[15] = '{32'h80000005, 32'h40000000, 32'h80000000, 1'b0, 1'b0};

    rst_n_in = 1'b0;
    start_in = 1'b0;
    a_in     = '0;
    b_in     = '0;
    repeat (3) @(negedge clk_in);
    chk("reset busy", 32'(busy_out), 32'd0);
    chk("reset done", 32'(done_out), 32'd0);
    chk("reset fpm", fpm_out, 32'd0);
    chk("reset ovf", 32'(overflow_out), 32'd0);
    chk("reset unf", 32'(underflow_out), 32'd0);
    rst_n_in = 1'b1;

    for (int i = 0; i < 16; i++) begin
      run_op(vecs[i].a, vecs[i].b, r, o, u);
      chk($sformatf("vec%0d result", i), r, vecs[i].r);
      chk($sformatf("vec%0d ovf", i), 32'(o), 32'(vecs[i].o));
      chk($sformatf("vec%0d unf", i), 32'(u), 32'(vecs[i].u));
      $display("vec%0d a=%08h b=%08h fpm=%08h ovf=%0b unf=%0b", i, vecs[i].a, vecs[i].b, r, o, u);
    end

    for (int i = 0; i < 40; i++) begin
      a = rand_op();
      b = rand_op();
      ref_mul(a, b, er, eo, eu);
      run_op(a, b, r, o, u);
      chk($sformatf("rand%0d result", i), r, er);
      chk($sformatf("rand%0d ovf", i), 32'(o), 32'(eo));
      chk($sformatf("rand%0d unf", i), 32'(u), 32'(eu));
      $display("rand%0d a=%08h b=%08h fpm=%08h ovf=%0b unf=%0b", i, a, b, r, o, u);
    end

    // start held high: one result per 27 cycles, operands sampled only in IDLE
    @(negedge clk_in);
    a_in     = 32'h3FC00000;
    b_in     = 32'h40000000;
    start_in = 1'b1;
    @(posedge clk_in);
    for (int s = 1; s <= 56; s++) begin
      @(negedge clk_in);
      if (done_out) done_at.push_back(s);
      if (s == 5) begin
        a_in = 32'h71800000;
        b_in = 32'h71800000;
      end
      if (s == 26) begin
        chk("held busy in done", 32'(busy_out), 32'd1);
        chk("held first result", fpm_out, 32'h40400000);
      end
      if (s == 27) chk("held idle gap", 32'(busy_out), 32'd0);
      if (s == 28) chk("held second accept", 32'(busy_out), 32'd1);
      if (s == 30) begin
        a_in = 32'h3F800000;
        b_in = 32'h3F800000;
      end
      if (s == 50) start_in = 1'b0;
      if (s == 52) begin
        chk("held result kept", fpm_out, 32'h40400000);
        chk("held ovf kept", 32'(overflow_out), 32'd0);
      end
      if (s == 53) begin
        chk("held second result", fpm_out, 32'h7F800000);
        chk("held second ovf", 32'(overflow_out), 32'd1);
      end
    end
    chk("held done count", 32'(done_at.size()), 32'd2);
    chk("held done pos0", 32'(done_at.size() > 0 ? done_at[0] : -1), 32'd26);
    chk("held done pos1", 32'(done_at.size() > 1 ? done_at[1] : -1), 32'd53);
    $display("held-start: %0d done pulses", done_at.size());

    // reset during operation aborts with no trace
    @(negedge clk_in);
    a_in     = 32'h3FC00000;
    b_in     = 32'h3FC00000;
    start_in = 1'b1;
    @(posedge clk_in);
    #1;
    start_in = 1'b0;
    repeat (10) @(negedge clk_in);
    rst_n_in = 1'b0;
    #1;
    chk("abort busy", 32'(busy_out), 32'd0);
    chk("abort done", 32'(done_out), 32'd0);
    chk("abort fpm", fpm_out, 32'd0);
    chk("abort ovf", 32'(overflow_out), 32'd0);
    chk("abort unf", 32'(underflow_out), 32'd0);
    repeat (2) @(negedge clk_in);
    rst_n_in = 1'b1;
    ndone = 0;
    for (int s = 0; s < 30; s++) begin
      @(negedge clk_in);
      if (done_out || fpm_out != 32'd0) ndone++;
    end
    chk("no trace after abort", 32'(ndone), 32'd0);
    run_op(32'h3FC00000, 32'h3FC00000, r, o, u);
    chk("post-abort result", r, 32'h40100000);
    chk("post-abort flags", {30'd0, o, u}, 32'd0);
    $display("reset-abort: post result %08h", r);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
